// File: rtl/esd_pkg.sv
// Shared types and constants for the emergency-shutdown controller tile.
package esd_pkg;

  typedef enum logic [1:0] {
    ST_SAFE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } esd_state_e;

  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEBOUNCE_CYC_DEF = 4;
  localparam int unsigned WDG_TIMEOUT_DEF  = 25_000_000;

  localparam int unsigned UI_ESTOP_A_N = 0;
  localparam int unsigned UI_ESTOP_B_N = 1;
  localparam int unsigned UI_ACK_N     = 2;
  localparam int unsigned UI_WDG_KICK  = 3;

  localparam int unsigned UO_SHUTDOWN  = 0;
  localparam int unsigned UO_LED       = 1;
  localparam int unsigned UO_STATE_LSB = 2;
  localparam int unsigned UO_STATE_MSB = 3;

endpackage

// File: rtl/esd_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer; emits the
// debounced level and a one-cycle pulse on its 1->0 transition.
module esd_debounce #(
  parameter int unsigned N         = 4,
  parameter logic        RST_VAL   = 1'b1,
  parameter logic        FAST_FALL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_o,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= RST_VAL;
      s2_q    <= RST_VAL;
      cnt_q   <= '0;
      level_q <= RST_VAL;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  // FAST_FALL drops the level on the first low sample; only rises are filtered.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (FAST_FALL && !s2_q) begin
      level_d = 1'b0;
    end else if (s2_q != level_q) begin
      if (cnt_q == CW'(N - 1)) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_d = level_q & ~level_d;
  end

  assign sync_o  = s2_q;
  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/tt_um_esd_controller.sv
// Emergency-shutdown controller: filtered E-STOPs, ACK and watchdog kick
// drive a fail-safe shutdown output that is held high unless in RUN.
module tt_um_esd_controller
  import esd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned WDG_TIMEOUT  = WDG_TIMEOUT_DEF
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned WDG_W = $clog2(WDG_TIMEOUT + 1);

  logic estop_sync, estop_released, estop_fall;
  logic ack_sync, ack_level, ack_press;
  logic estop;

  esd_debounce #(
    .N         (DEBOUNCE_CYC),
    .RST_VAL   (1'b1),
    .FAST_FALL (1'b1)
  ) u_estop_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (ui_in[UI_ESTOP_A_N] & ui_in[UI_ESTOP_B_N]),
    .sync_o  (estop_sync),
    .level_o (estop_released),
    .fall_o  (estop_fall)
  );

  esd_debounce #(
    .N         (DEBOUNCE_CYC),
    .RST_VAL   (1'b1),
    .FAST_FALL (1'b0)
  ) u_ack_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (ui_in[UI_ACK_N]),
    .sync_o  (ack_sync),
    .level_o (ack_level),
    .fall_o  (ack_press)
  );

  // The raw synchronized level covers the cycle before the filter drops.
  assign estop = ~estop_sync | ~estop_released;

  logic kick_s1_q, kick_s2_q, kick_prev_q;
  logic kick_evt;

  logic [WDG_W-1:0] wdg_cnt_q, wdg_cnt_d;
  logic             wdg_to;

  esd_state_e state_q, state_d;
  logic       shutdown_q, shutdown_d;
  logic       led_q;
  logic [1:0] state_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kick_s1_q   <= 1'b0;
      kick_s2_q   <= 1'b0;
      kick_prev_q <= 1'b0;
    end else begin
      kick_s1_q   <= ui_in[UI_WDG_KICK];
      kick_s2_q   <= kick_s1_q;
      kick_prev_q <= kick_s2_q;
    end
  end

  assign kick_evt = kick_s2_q & ~kick_prev_q;

  always_comb begin
    wdg_cnt_d = wdg_cnt_q;
    if (kick_evt || state_q == ST_SAFE || state_q == ST_FAULT) begin
      wdg_cnt_d = '0;
    end else if (wdg_cnt_q != WDG_W'(WDG_TIMEOUT)) begin
      wdg_cnt_d = wdg_cnt_q + WDG_W'(1);
    end
  end

  assign wdg_to = (wdg_cnt_q == WDG_W'(WDG_TIMEOUT - 1)) && !kick_evt;

  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = ST_FAULT;
    end else begin
      unique case (state_q)
        ST_SAFE, ST_FAULT: if (ack_press) state_d = ST_ARMED;
        ST_ARMED: begin
          if (kick_evt)    state_d = ST_RUN;
          else if (wdg_to) state_d = ST_FAULT;
        end
        ST_RUN:   if (wdg_to) state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end
    shutdown_d = (state_q != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SAFE;
      wdg_cnt_q    <= '0;
      shutdown_q   <= 1'b1;
      led_q        <= 1'b1;
      state_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wdg_cnt_q    <= wdg_cnt_d;
      shutdown_q   <= shutdown_d;
      led_q        <= shutdown_d;
      state_code_q <= state_q;
    end
  end

  assign uo_out[UO_SHUTDOWN]                = shutdown_q;
  assign uo_out[UO_LED]                     = led_q;
  assign uo_out[UO_STATE_MSB:UO_STATE_LSB]  = state_code_q;
  assign uo_out[7:4]                        = '0;
  assign uio_out                            = '0;
  assign uio_oe                             = '0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:4], uio_in, estop_fall, ack_sync, ack_level};

endmodule

// File: tb/tb_tt_um_esd_controller.sv
// Directed and randomized checks of the ESD controller against an
// operation-level model of its states and watchdog deadline.
module tb_tt_um_esd_controller;

  localparam int unsigned WDG_T = 300;
  localparam int unsigned DEB   = 4;

  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  tt_um_esd_controller #(
    .DEBOUNCE_CYC (DEB),
    .WDG_TIMEOUT  (WDG_T)
  ) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  typedef enum int {M_SAFE, M_ARMED, M_RUN, M_FAULT} mstate_e;

  int      checks = 0;
  int      errors = 0;
  longint  cyc = 0;
  longint  deadline = 0;
  mstate_e m_state = M_SAFE;

  task automatic tick(input longint n);
    for (longint i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    cyc += n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] code_of(input mstate_e s);
    case (s)
      M_SAFE:  return 2'b00;
      M_ARMED: return 2'b01;
      M_RUN:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic expect_model(input string tag);
    logic sd;
    sd = (m_state == M_RUN) ? 1'b0 : 1'b1;
    check({tag, "/state"},    32'(uo_out[3:2]), 32'(code_of(m_state)));
    check({tag, "/shutdown"}, 32'(uo_out[0]),   32'(sd));
    check({tag, "/led"},      32'(uo_out[1]),   32'(sd));
  endtask

  // Step past a watchdog deadline that would otherwise fall inside the next operation.
  task automatic guard(input longint dur);
    if ((m_state == M_ARMED || m_state == M_RUN) && deadline < cyc + dur + 15) begin
      if (deadline + 15 > cyc) tick(deadline + 15 - cyc);
      m_state = M_FAULT;
    end
  endtask

  task automatic op_kick();
    longint start;
    guard(10);
    start = cyc;
    ui_in[3] = 1'b1;
    tick(2);
    ui_in[3] = 1'b0;
    if (m_state == M_ARMED || m_state == M_RUN) begin
      m_state  = M_RUN;
      deadline = start + WDG_T + 3;
    end
    tick(8);
  endtask

  task automatic op_ack();
    longint start;
    guard(22);
    start = cyc;
    ui_in[2] = 1'b0;
    tick(10);
    ui_in[2] = 1'b1;
    if (m_state == M_SAFE || m_state == M_FAULT) begin
      m_state  = M_ARMED;
      deadline = start + WDG_T + 7;
    end
    tick(12);
  endtask

  task automatic op_estop(input int which, input longint len);
    guard(len + 12);
    ui_in[which] = 1'b0;
    tick(len);
    ui_in[which] = 1'b1;
    m_state = M_FAULT;
    tick(12);
  endtask

  task automatic op_wait(input longint w);
    guard(w);
    tick(w);
  endtask

  initial begin
    int n;
    int sel;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'b0000_0111;
    rst_n  = 1'b0;

    tick(100);
    rst_n = 1'b1;
    tick(100);
    check("reset/shutdown", 32'(uo_out[0]),   32'd1);
    check("reset/led",      32'(uo_out[1]),   32'd1);
    check("reset/state",    32'(uo_out[3:2]), 32'd0);
    check("reset/upper",    32'(uo_out[7:4]), 32'd0);
    check("reset/uio_out",  32'(uio_out),     32'd0);
    check("reset/uio_oe",   32'(uio_oe),      32'd0);

    ui_in[2] = 1'b0;
    tick(10);
    ui_in[2] = 1'b1;
    tick(100);
    check("ack/state",    32'(uo_out[3:2]), 32'd1);
    check("ack/shutdown", 32'(uo_out[0]),   32'd1);

    ui_in[3] = 1'b1;
    n = 0;
    while (n < 5 && uo_out[0] !== 1'b0) begin
      tick(1);
      n++;
      if (n == 2) ui_in[3] = 1'b0;
    end
    ui_in[3] = 1'b0;
    check("kick/latency_shutdown", 32'(uo_out[0]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(WDG_T / 2);
      ui_in[3] = 1'b1;
      tick(2);
      ui_in[3] = 1'b0;
    end
    tick(8);
    check("kick/sustained_run", 32'(uo_out[0]), 32'd0);

    for (int which = 0; which < 2; which++) begin
      ui_in[which] = 1'b0;
      n = 0;
      while (n < 4 && uo_out[0] !== 1'b1) begin
        tick(1);
        n++;
      end
      check($sformatf("estop%0d/latency_shutdown", which), 32'(uo_out[0]), 32'd1);
      check($sformatf("estop%0d/led", which),              32'(uo_out[1]), 32'd1);
      check($sformatf("estop%0d/state", which),            32'(uo_out[3:2]), 32'd3);
      tick(5);
      ui_in[which] = 1'b1;
      tick(20);
      check($sformatf("estop%0d/latched", which), 32'(uo_out[3:2]), 32'd3);
      ui_in[2] = 1'b0; tick(10); ui_in[2] = 1'b1; tick(12);
      ui_in[3] = 1'b1; tick(2);  ui_in[3] = 1'b0; tick(8);
      check($sformatf("estop%0d/rearm_run", which), 32'(uo_out[0]), 32'd0);
    end

    ui_in[3] = 1'b1;
    tick(2);
    ui_in[3] = 1'b0;
    tick(WDG_T - 52);
    check("wdg/before_timeout", 32'(uo_out[0]), 32'd0);
    tick(54);
    check("wdg/after_timeout_shutdown", 32'(uo_out[0]),   32'd1);
    check("wdg/after_timeout_state",    32'(uo_out[3:2]), 32'd3);
    ui_in[2] = 1'b0; tick(10); ui_in[2] = 1'b1; tick(12);
    ui_in[3] = 1'b1; tick(2);  ui_in[3] = 1'b0; tick(8);
    check("wdg/recover_run", 32'(uo_out[0]), 32'd0);

    ui_in[1] = 1'b0;
    tick(6);
    ui_in[2] = 1'b0; tick(10); ui_in[2] = 1'b1; tick(12);
    check("ack_in_estop/state", 32'(uo_out[3:2]), 32'd3);
    ui_in[1] = 1'b1;
    tick(20);
    check("ack_in_estop/after_release", 32'(uo_out[3:2]), 32'd3);
    check("ack_in_estop/shutdown",      32'(uo_out[0]),   32'd1);

    ui_in[2] = 1'b0; tick(10); ui_in[2] = 1'b1; tick(12);
    check("kick_estop/armed", 32'(uo_out[3:2]), 32'd1);
    ui_in[3] = 1'b1;
    ui_in[0] = 1'b0;
    tick(2);
    ui_in[3] = 1'b0;
    tick(10);
    check("kick_estop/state",    32'(uo_out[3:2]), 32'd3);
    check("kick_estop/shutdown", 32'(uo_out[0]),   32'd1);
    ui_in[0] = 1'b1;
    tick(20);

    ui_in[2] = 1'b0; tick(10); ui_in[2] = 1'b1; tick(12);
    ui_in[3] = 1'b1; tick(2);  ui_in[3] = 1'b0; tick(8);
    check("async_rst/run", 32'(uo_out[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst/shutdown", 32'(uo_out[0]),   32'd1);
    check("async_rst/led",      32'(uo_out[1]),   32'd1);
    check("async_rst/state",    32'(uo_out[3:2]), 32'd0);
    tick(5);
    rst_n = 1'b1;
    tick(10);
    m_state = M_SAFE;
    expect_model("post_reset");

    for (int i = 0; i < 50; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2) begin
        op_kick();
      end else if (sel <= 5) begin
        op_ack();
      end else if (sel <= 7) begin
        op_estop(int'($urandom_range(0, 1)), longint'($urandom_range(2, 12)));
      end else begin
        op_wait(longint'($urandom_range(1, WDG_T + WDG_T / 2)));
      end
      expect_model($sformatf("rand%0d_op%0d", i, sel));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
